fft_result_spi_tx: RTL
======================

Name: fft_result_spi_tx

Overview:
Drains the FFT result stream into a local frame buffer. It then serves the buffer to the MCU as an SPI mode-0 slave transmitter. This is the return path of the SPI load adapter that feeds the FFT.
- Captures one complex word per clk while the FFT `done` is high.
- After POINTS words, flags `ready` and shifts words out MSB-first on `sdo`, clocked by the MCU's `sck` under `cs_n`.

Parameters:
- M, 9, log2 of FFT length.
- WIDTH, 16, bits per real/imag component.
- POINTS, 2**M, words per frame.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous reset, active-low.
- done  input  1  FFT output-valid; one result word on `wd` per cycle while high.
- wd  input  2*WIDTH  FFT result {re[2W-1:W], im[W-1:0]}.
- sck  input  1  SPI clock from MCU, asynchronous to clk.
- cs_n  input  1  SPI chip select, active-low, asynchronous.
- sdo  output  1  SPI serial data to MCU.
- ready  output  1  full frame buffered and not yet fully read.
- busy  output  1  high in CAPTURE or SHIFT.
- overflow  output  1  sticky: a new `done` burst arrived while a frame was still held.

Behaviour:
- Reset: clk, synchronous, active-low. On reset, all outputs are 0, state = IDLE, and all counters are 0. Buffer contents are don't-care.
- Synchronizers: `sck` and `cs_n` each pass through 2-FF synchronizers plus one history FF for edge detect. clk must be ≥ 8× sck. Edge detection latency is 3 clk.
- States:
  - IDLE → CAPTURE: on the first cycle `done` = 1. That cycle's `wd` is written to buf[0] and cap_idx becomes 1.
  - CAPTURE: on each cycle with `done` = 1, write `wd` to buf[cap_idx] and increment cap_idx. A cycle with `done` = 0 writes nothing and holds the index; gaps are allowed. The write that makes cap_idx reach POINTS moves the FSM to READY. `ready` goes high the next cycle.
  - READY: `done` is ignored. If `done` rises (0→1 on registered `done`), set `overflow`. A synchronized `cs_n` falling edge moves to SHIFT with tx_word = 0 and tx_bit = 0. shreg is loaded from the prefetched buf[0].
  - SHIFT: `sdo` = shreg[2W-1] continuously.
    - Synchronized `sck` rising: bit is sampled by the master; increment tx_bit.
    - Synchronized `sck` falling: shift shreg left. When tx_bit wraps from 2W to 0, load shreg from the prefetched buf[tx_word+1] instead and increment tx_word.
    - Next-word prefetch is issued on the load cycle. RAM read latency is 1 clk, so the word is always valid before the next falling edge.
    - After the last rising edge of word POINTS-1, go to FLUSH.
  - FLUSH: `sdo` = 0. Wait for synchronized `cs_n` high, then go to IDLE. `ready` drops when entering FLUSH.
  - `cs_n` rising mid-SHIFT (frame incomplete): abort to READY. tx_word and tx_bit reset to 0 and buf[0] is re-prefetched, so the next select restarts the frame from word 0.
- Bit order: word 0 first. Within a word, re MSB … re LSB, then im MSB … im LSB, for 32 bits per word.
- `sdo` = 0 whenever state ≠ SHIFT.
- `overflow` clears only on reset.
- Reset mid-capture or mid-shift returns to IDLE immediately. A partial frame is discarded.
- Simultaneous `done` and `cs_n` fall in IDLE: capture proceeds and the `cs_n` edge is ignored. The MCU must poll `ready` first.

Decomposition:
- fft_pkg holds:
  - constants M, WIDTH, POINTS;
  - typedef cplx_t (packed re/im, WIDTH each);
  - enum tx_state_t {IDLE, CAPTURE, READY, SHIFT, FLUSH}.
- Sub-module frame_buffer: simple dual-port RAM, POINTS × 2*WIDTH, 1 write port and 1 registered read port, single clk, inferable as BRAM.

Test Plan:
- Ramp capture/readback:
  - Stimulus: `done` high for 512 clk with `wd` = {idx[15:0], ~idx[15:0]}; then a full SPI read at sck = clk/16.
  - Response: `ready` = 1 one cycle after the 512th write. The first 32 bits received are 0x0000FFFF and word 511 is 0x01FFFE00. `ready` = 0 in FLUSH. State is IDLE after `cs_n` goes high.
- Gapped `done`:
  - Stimulus: `done` toggles 1/0 every cycle for 1024 cycles.
  - Response: exactly 512 words are captured in order, and readback matches the ramp.
- Aborted read:
  - Stimulus: deassert `cs_n` after 40 bits, then reselect and read the full frame.
  - Response: the second transfer starts at word 0 (0x0000FFFF), and `ready` stays 1 until the full frame is sent.
- Overflow:
  - Stimulus: a second `done` burst while in READY.
  - Response: `overflow` = 1. Buffer contents are unchanged (readback equals the first frame).
- Reset mid-shift:
  - Stimulus: drive `reset` = 0 for one clk during word 3.
  - Response: `sdo`, `ready`, `busy` and `overflow` = 0 next cycle; state is IDLE and a new capture is accepted.
- Idle SPI activity:
  - Stimulus: toggle `cs_n` and `sck` in IDLE.
  - Response: `sdo` stays 0 and there is no state change.

Source files
------------

// File: rtl/fft_result_spi_tx_pkg.sv
// Shared constants and types for the FFT result return path.
package fft_pkg;
  localparam int M      = 9;
  localparam int WIDTH  = 16;
  localparam int POINTS = 2**M;

  typedef struct packed {
    logic [WIDTH-1:0] re;
    logic [WIDTH-1:0] im;
  } cplx_t;

  typedef enum logic [2:0] {IDLE, CAPTURE, READY, SHIFT, FLUSH} tx_state_t;
endpackage

// File: rtl/fft_result_spi_tx_if.sv
// FFT result stream plus SPI slave pins; the MCU/FFT side drives master.
interface fft_result_spi_tx_if;
  import fft_pkg::*;

  logic  done;
  cplx_t wd;
  logic  sck;
  logic  cs_n;
  logic  sdo;
  logic  ready;
  logic  busy;
  logic  overflow;

  modport master (output done, wd, sck, cs_n, input sdo, ready, busy, overflow);
  modport slave  (input done, wd, sck, cs_n, output sdo, ready, busy, overflow);
endinterface

// File: rtl/fft_result_spi_tx_frame_buffer.sv
// Simple dual-port frame RAM: one write port, one registered read port.
module frame_buffer #(
  parameter int DEPTH = 512,
  parameter int AW    = 9,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wdat,
  input  logic [AW-1:0] ra,
  output logic [DW-1:0] rdat
);
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wdat;
    rdat <= mem[ra];
  end
endmodule

// File: rtl/fft_result_spi_tx.sv
// Buffers one FFT frame and serves it MSB-first as an SPI mode-0 slave.
module fft_result_spi_tx #(
  parameter int M      = fft_pkg::M,
  parameter int POINTS = 2**M
) (
  input logic               clk,
  input logic               reset,
  fft_result_spi_tx_if.slave bus
);
  import fft_pkg::*;

  localparam int WW = 2*WIDTH;

  tx_state_t     state, state_d;
  logic [2:0]    sck_sync, cs_sync;
  logic          done_q;
  logic [M:0]    cap_idx;
  logic [M-1:0]  tx_word, pf_addr;
  logic [5:0]    tx_bit;
  logic [WW-1:0] shreg, rd_data;
  logic          overflow;

  logic sck_rise, sck_fall, cs_fall, cs_rise, cs_high, done_rise;
  logic we, last_cap, last_bit;

  // [0],[1] synchronize, [2] is the edge-detect history
  assign sck_rise  =  sck_sync[1] & ~sck_sync[2];
  assign sck_fall  = ~sck_sync[1] &  sck_sync[2];
  assign cs_fall   = ~cs_sync[1]  &  cs_sync[2];
  assign cs_rise   =  cs_sync[1]  & ~cs_sync[2];
  assign cs_high   =  cs_sync[1];
  assign done_rise =  bus.done & ~done_q;

  assign we       = bus.done && (state == IDLE || state == CAPTURE);
  assign last_cap = we && (cap_idx == (M+1)'(POINTS-1));
  assign last_bit = sck_rise && (tx_word == M'(POINTS-1)) && (tx_bit == 6'(WW-1));

  frame_buffer #(.DEPTH(POINTS), .AW(M), .DW(WW)) u_buf (
    .clk  (clk),
    .we   (we),
    .wa   (cap_idx[M-1:0]),
    .wdat (bus.wd),
    .ra   (pf_addr),
    .rdat (rd_data)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (bus.done) state_d = CAPTURE;
      CAPTURE: if (last_cap) state_d = READY;
      READY:   if (cs_fall)  state_d = SHIFT;
      SHIFT:   if (cs_rise)  state_d = READY;
               else if (last_bit) state_d = FLUSH;
      FLUSH:   if (cs_high)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.sdo      = (state == SHIFT) & shreg[WW-1];
  assign bus.ready    = (state == READY) || (state == SHIFT);
  assign bus.busy     = (state == CAPTURE) || (state == SHIFT);
  assign bus.overflow = overflow;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sck_sync <= '0;
      cs_sync  <= '1;
      done_q   <= 1'b0;
      cap_idx  <= '0;
      tx_word  <= '0;
      tx_bit   <= '0;
      pf_addr  <= '0;
      shreg    <= '0;
      overflow <= 1'b0;
    end else begin
      sck_sync <= {sck_sync[1:0], bus.sck};
      cs_sync  <= {cs_sync[1:0], bus.cs_n};
      done_q   <= bus.done;
      if (we) cap_idx <= cap_idx + 1'b1;
      unique case (state)
        CAPTURE: if (last_cap) pf_addr <= '0;
        READY: begin
          if (done_rise) overflow <= 1'b1;
          if (cs_fall) begin
            shreg   <= rd_data;
            tx_word <= '0;
            tx_bit  <= '0;
            pf_addr <= M'(1);
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            tx_word <= '0;
            tx_bit  <= '0;
            pf_addr <= '0;
          end else if (sck_rise) begin
            tx_bit <= tx_bit + 1'b1;
          end else if (sck_fall) begin
            // word boundary: take the prefetched word and fetch the one after it
            if (tx_bit == 6'(WW)) begin
              shreg   <= rd_data;
              tx_bit  <= '0;
              tx_word <= tx_word + 1'b1;
              pf_addr <= pf_addr + 1'b1;
            end else begin
              shreg <= shreg << 1;
            end
          end
        end
        FLUSH: if (cs_high) cap_idx <= '0;
        default: ;
      endcase
    end
  end
endmodule
